// File: rtl/skyhop_pkg.sv
// -----------------------------------------------------------------------------
// skyhop_pkg
//   Shared definitions for the map layer store.
//   LAYER_W   : columns per map layer
//   MAP_DEPTH : number of layers held by the store
//   PTR_W     : width of head/tail slot pointers
//   state_t   : Gray-coded store FSM state (neighbouring states differ by 1 bit)
//   layer_t   : one stored layer, block-present map plus special-block flags,
//               index 0 = leftmost column
//
//   Optional build macro understood by this codebase slice:
//   MAP_LAYER_STORE_OVERFLOW_EN (adds the sticky overflow flag)
// -----------------------------------------------------------------------------
package skyhop_pkg;

    localparam int unsigned LAYER_W   = 7;
    localparam int unsigned MAP_DEPTH = 4;
    localparam int unsigned PTR_W     = $clog2(MAP_DEPTH);

    typedef enum logic [1:0] {
        S_START = 2'b00,
        S_FILL  = 2'b01,
        S_READY = 2'b11,
        S_WAIT  = 2'b10
    } state_t;

    typedef struct packed {
        logic [0:LAYER_W-1] map;
        logic [0:LAYER_W-1] special;
    } layer_t;

endpackage

// File: rtl/map_layer_store_if.sv
// -----------------------------------------------------------------------------
// map_layer_store_if
//   Bus between the layer producer / reader and the map layer store.
//   load_layer, layer_map, block_type : layer load beat from the producer
//   scroll                            : drop bottom layer, fetch a new top one
//   rd_en, rd_row, rd_col             : read request (row 0 = oldest layer)
//   generate_map                      : one-cycle request to the producer
//   store_ready, layer_count          : fill status
//   rd_valid, rd_block, rd_special    : read response, one cycle after rd_en
//   overflow                          : sticky dropped-load flag, only when
//                                       MAP_LAYER_STORE_OVERFLOW_EN is defined
//   Modports: master = producer/reader side, slave = the store.
// -----------------------------------------------------------------------------
interface map_layer_store_if;
    import skyhop_pkg::*;

    logic                   load_layer;
    logic [0:LAYER_W-1]     layer_map;
    logic [0:LAYER_W-1]     block_type;
    logic                   scroll;
    logic                   rd_en;
    logic [PTR_W-1:0]       rd_row;
    logic [2:0]             rd_col;
    logic                   generate_map;
    logic                   store_ready;
    logic [2:0]             layer_count;
    logic                   rd_valid;
    logic                   rd_block;
    logic                   rd_special;
`ifdef MAP_LAYER_STORE_OVERFLOW_EN
    logic                   overflow;
`endif

    modport master (
        output load_layer, layer_map, block_type, scroll,
        output rd_en, rd_row, rd_col,
        input  generate_map, store_ready, layer_count,
        input  rd_valid, rd_block, rd_special
`ifdef MAP_LAYER_STORE_OVERFLOW_EN
        , input overflow
`endif
    );

    modport slave (
        input  load_layer, layer_map, block_type, scroll,
        input  rd_en, rd_row, rd_col,
        output generate_map, store_ready, layer_count,
        output rd_valid, rd_block, rd_special
`ifdef MAP_LAYER_STORE_OVERFLOW_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/map_layer_store_layer_ram.sv
// -----------------------------------------------------------------------------
// layer_ram
//   MAP_DEPTH x layer_t register file, one write port, one registered read
//   port. A read and write to the same slot in one cycle return the old word.
//   clk, rst_n   : clock, asynchronous active-low reset (clears contents)
//   we/waddr/wdata : write port
//   re/raddr       : read request, rdata valid the following cycle
// -----------------------------------------------------------------------------
module layer_ram
    import skyhop_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  layer_t           wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output layer_t           rdata
);

    layer_t mem [MAP_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '{default: '0};
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/map_layer_store.sv
// -----------------------------------------------------------------------------
// map_layer_store
//   Holds the last MAP_DEPTH map layers in a circular buffer (head = oldest,
//   tail = next write slot). After reset it requests layers from the producer,
//   fills the buffer, then on scroll drops the oldest layer and requests one
//   replacement. Reads address rows relative to the oldest layer.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : map_layer_store_if.slave (load, scroll, read and status signals)
//   Build macro MAP_LAYER_STORE_OVERFLOW_EN adds bus.overflow, a sticky flag
//   set whenever a load beat is dropped.
// -----------------------------------------------------------------------------
module map_layer_store
    import skyhop_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    map_layer_store_if.slave     bus
);

    state_t           state, state_nxt;
    logic [PTR_W-1:0] head, head_nxt;
    logic [PTR_W-1:0] tail, tail_nxt;
    logic [2:0]       count, count_nxt;
    logic             gen_q, gen_nxt;
    logic             ready_q;
    logic             wr_en;

    logic             rd_valid_q;
    logic             rd_zero_q;
    logic [2:0]       rd_col_q;
    logic             rd_zero;
    layer_t           rd_word;
    logic             blk_sel, spc_sel;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_START;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            gen_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
            count   <= count_nxt;
            gen_q   <= gen_nxt;
            ready_q <= (state_nxt == S_READY);
        end
    end

    // Loads in S_START and S_READY are dropped simply by not enabling a write.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        gen_nxt   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            S_START: begin
                gen_nxt   = 1'b1;
                state_nxt = S_FILL;
            end
            S_FILL: begin
                if (bus.load_layer) begin
                    wr_en     = 1'b1;
                    tail_nxt  = tail + 1'b1;
                    count_nxt = count + 3'd1;
                    if (count == 3'(MAP_DEPTH - 1)) state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (bus.scroll) begin
                    head_nxt  = head + 1'b1;
                    count_nxt = count - 3'd1;
                    gen_nxt   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.load_layer) begin
                    wr_en     = 1'b1;
                    tail_nxt  = tail + 1'b1;
                    count_nxt = count + 3'd1;
                    state_nxt = S_READY;
                end
            end
            default: state_nxt = S_START;
        endcase
    end

    assign bus.generate_map = gen_q;
    assign bus.store_ready  = ready_q;
    assign bus.layer_count  = count;

    // ---------------------------------------------------------------- storage
    layer_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (tail),
        .wdata ('{map: bus.layer_map, special: bus.block_type}),
        .re    (bus.rd_en),
        .raddr (head + bus.rd_row),
        .rdata (rd_word)
    );

    // ---------------------------------------------------------------- read
    // Row/column range is judged against the pre-update count and carried
    // alongside the registered RAM word so the response can be masked.
    assign rd_zero = ({1'b0, bus.rd_row} >= count) || (bus.rd_col > 3'(LAYER_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b0;
            rd_col_q   <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_zero_q <= rd_zero;
                rd_col_q  <= bus.rd_col;
            end
        end
    end

    always_comb begin
        blk_sel = 1'b0;
        spc_sel = 1'b0;
        for (int unsigned c = 0; c < LAYER_W; c++) begin
            if (rd_col_q == 3'(c)) begin
                blk_sel = rd_word.map[c];
                spc_sel = rd_word.special[c];
            end
        end
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_block   = rd_valid_q & ~rd_zero_q & blk_sel;
    assign bus.rd_special = rd_valid_q & ~rd_zero_q & spc_sel;

`ifdef MAP_LAYER_STORE_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.load_layer && (state == S_START || state == S_READY)) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.overflow = ovf_q;
`endif

endmodule
